// File: rtl/pdp8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pdp8_pkg
// Description : Shared PDP-8 types and constants. Includes the memory-access
//               initiator's access kinds, state encoding and auto-index window.
// Revision    : 1.0 - initial release
// ============================================================================
package pdp8_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 12;

    // Indirect references through these page-zero words pre-increment the pointer
    localparam logic [11:0] AUTO_LO = 12'o0010;
    localparam logic [11:0] AUTO_HI = 12'o0017;

    typedef enum logic [1:0] {
        READ    = 2'd0,
        WRITE   = 2'd1,
        RMW     = 2'd2,
        EA_ONLY = 2'd3
    } access_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_IND_RD   = 3'd1,
        S_IND_WAIT = 3'd2,
        S_AUTO_WR  = 3'd3,
        S_OP_RD    = 3'd4,
        S_OP_WAIT  = 3'd5,
        S_OP_WR    = 3'd6,
        S_DONE     = 3'd7
    } mi_state_t;

    // First state of the operand phase once the effective address is known
    function automatic mi_state_t access_state(input access_t acc);
        case (acc)
            READ, RMW: return S_OP_RD;
            WRITE:     return S_OP_WR;
            default:   return S_DONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pdp8_mem_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : pdp8_mem_initiator_if
// Description : Exec memory port between the initiator (master) and the
//               memory responder (slave). Read data is returned the cycle
//               after a read request; writes complete in their request cycle.
// Revision    : 1.0 - initial release
// Signals     : exec_rd_req/addr (m->s), exec_rd_data (s->m),
//               exec_wr_req/addr/data (m->s)
// ============================================================================
interface pdp8_mem_initiator_if #(
    parameter int ADDR_WIDTH = pdp8_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = pdp8_pkg::DATA_WIDTH
);
    logic                  exec_rd_req;
    logic [ADDR_WIDTH-1:0] exec_rd_addr;
    logic [DATA_WIDTH-1:0] exec_rd_data;
    logic                  exec_wr_req;
    logic [ADDR_WIDTH-1:0] exec_wr_addr;
    logic [DATA_WIDTH-1:0] exec_wr_data;

    modport master (
        output exec_rd_req, exec_rd_addr,
        input  exec_rd_data,
        output exec_wr_req, exec_wr_addr, exec_wr_data
    );

    modport slave (
        input  exec_rd_req, exec_rd_addr,
        output exec_rd_data,
        input  exec_wr_req, exec_wr_addr, exec_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/pdp8_ea_calc.sv
`default_nettype none
// ============================================================================
// Module      : pdp8_ea_calc
// Description : Combinational MRI address decode: base address (page zero or
//               current page), indirect flag and auto-index flag.
// Revision    : 1.0 - initial release
// Ports       : i_instr  - MRI word (I=[8], Z=[7], offset=[6:0])
//               i_pc     - address of the instruction
//               o_base   - base address
//               o_indirect - I bit
//               o_auto   - indirect through an auto-index location
// ============================================================================
module pdp8_ea_calc #(
    parameter int ADDR_WIDTH = pdp8_pkg::ADDR_WIDTH
) (
    input  logic [11:0]           i_instr,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    output logic [ADDR_WIDTH-1:0] o_base,
    output logic                  o_indirect,
    output logic                  o_auto
);
    import pdp8_pkg::*;

    logic [ADDR_WIDTH-1:0] w_base;

    always_comb begin
        w_base      = '0;
        w_base[6:0] = i_instr[6:0];
        if (i_instr[7]) begin
            w_base[ADDR_WIDTH-1:7] = i_pc[ADDR_WIDTH-1:7];
        end
    end

    assign o_base     = w_base;
    assign o_indirect = i_instr[8];
    assign o_auto     = i_instr[8]
                        && (w_base >= ADDR_WIDTH'(AUTO_LO))
                        && (w_base <= ADDR_WIDTH'(AUTO_HI));

    // Opcode and in-page pc bits play no part in address formation
    logic w_unused;
    assign w_unused = ^{i_instr[11:9], i_pc[6:0]};

endmodule
`default_nettype wire

// File: rtl/pdp8_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module      : pdp8_mem_initiator
// Description : Requesting end of the PDP-8 exec memory port. Takes one MRI
//               at a time, forms the effective address (direct, indirect,
//               auto-index) and performs a READ, WRITE, RMW or no access.
// Revision    : 1.0 - initial release
// Ports       : clk, reset_n (async, active low)
//               start/instr/pc/access/wr_data - request, sampled in IDLE
//               busy, done, ea, rd_operand, skip - status and results
//               mem - exec memory port (master side)
// ============================================================================
module pdp8_mem_initiator #(
    parameter int ADDR_WIDTH = pdp8_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = pdp8_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [11:0]           instr,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [1:0]            access,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ea,
    output logic [DATA_WIDTH-1:0] rd_operand,
    output logic                  skip,
    pdp8_mem_initiator_if.master  mem
);
    import pdp8_pkg::*;

    mi_state_t             r_state;
    mi_state_t             w_next;
    logic [11:0]           r_instr;
    logic [ADDR_WIDTH-1:0] r_pc;
    access_t               r_access;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [ADDR_WIDTH-1:0] r_ea;
    logic [DATA_WIDTH-1:0] r_rd_operand;
    logic                  r_skip;

    logic                  w_idle;
    logic [11:0]           w_calc_instr;
    logic [ADDR_WIDTH-1:0] w_calc_pc;
    access_t               w_access;
    logic [ADDR_WIDTH-1:0] w_base;
    logic                  w_indirect;
    logic                  w_auto;
    logic [ADDR_WIDTH-1:0] w_ptr_next;
    logic [DATA_WIDTH-1:0] w_incr;

    logic                  w_rd_req;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_wr_req;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;

    assign w_idle = (r_state == S_IDLE);

    // One decoder serves both phases: live inputs while deciding the first
    // transition out of IDLE, the captured request afterwards.
    assign w_calc_instr = w_idle ? instr : r_instr;
    assign w_calc_pc    = w_idle ? pc    : r_pc;
    assign w_access     = w_idle ? access_t'(access) : r_access;

    pdp8_ea_calc #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ea_calc (
        .i_instr    (w_calc_instr),
        .i_pc       (w_calc_pc),
        .o_base     (w_base),
        .o_indirect (w_indirect),
        .o_auto     (w_auto)
    );

    // Pointer fetched during IND_WAIT, pre-incremented for auto-index words
    assign w_ptr_next = w_auto ? ADDR_WIDTH'(mem.exec_rd_data) + ADDR_WIDTH'(1)
                               : ADDR_WIDTH'(mem.exec_rd_data);
    assign w_incr     = r_rd_operand + DATA_WIDTH'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_rd_req  = 1'b0;
        w_rd_addr = '0;
        w_wr_req  = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_indirect ? S_IND_RD : access_state(w_access);
                end
            end
            S_IND_RD: begin
                w_rd_req  = 1'b1;
                w_rd_addr = w_base;
                w_next    = S_IND_WAIT;
            end
            S_IND_WAIT: begin
                w_next = w_auto ? S_AUTO_WR : access_state(r_access);
            end
            S_AUTO_WR: begin
                // r_ea already holds the incremented pointer
                w_wr_req  = 1'b1;
                w_wr_addr = w_base;
                w_wr_data = DATA_WIDTH'(r_ea);
                w_next    = access_state(r_access);
            end
            S_OP_RD: begin
                w_rd_req  = 1'b1;
                w_rd_addr = r_ea;
                w_next    = S_OP_WAIT;
            end
            S_OP_WAIT: begin
                w_next = (r_access == RMW) ? S_OP_WR : S_DONE;
            end
            S_OP_WR: begin
                w_wr_req  = 1'b1;
                w_wr_addr = r_ea;
                w_wr_data = (r_access == RMW) ? w_incr : r_wr_data;
                w_next    = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instr      <= '0;
            r_pc         <= '0;
            r_access     <= READ;
            r_wr_data    <= '0;
            r_ea         <= '0;
            r_rd_operand <= '0;
            r_skip       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_instr   <= instr;
                        r_pc      <= pc;
                        r_access  <= access_t'(access);
                        r_wr_data <= wr_data;
                        r_skip    <= 1'b0;
                        // Direct EA is final here; indirect refines it in IND_WAIT
                        r_ea      <= w_base;
                    end
                end
                S_IND_WAIT: begin
                    r_ea <= w_ptr_next;
                end
                S_OP_WAIT: begin
                    r_rd_operand <= mem.exec_rd_data;
                end
                S_OP_WR: begin
                    if (r_access == RMW) begin
                        r_skip <= (w_incr == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = !w_idle;
    assign done       = (r_state == S_DONE);
    assign ea         = r_ea;
    assign rd_operand = r_rd_operand;
    assign skip       = r_skip;

    assign mem.exec_rd_req  = w_rd_req;
    assign mem.exec_rd_addr = w_rd_addr;
    assign mem.exec_wr_req  = w_wr_req;
    assign mem.exec_wr_addr = w_wr_addr;
    assign mem.exec_wr_data = w_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_pdp8_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdp8_mem_initiator
// Description : Scoreboard bench for pdp8_mem_initiator with a behavioural
//               memory responder and a spec-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pdp8_mem_initiator;
    import pdp8_pkg::*;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [11:0] instr   = '0;
    logic [11:0] pc      = '0;
    logic [1:0]  access  = '0;
    logic [11:0] wr_data = '0;
    logic        busy;
    logic        done;
    logic [11:0] ea;
    logic [11:0] rd_operand;
    logic        skip;

    pdp8_mem_initiator_if m ();

    pdp8_mem_initiator dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .instr      (instr),
        .pc         (pc),
        .access     (access),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .ea         (ea),
        .rd_operand (rd_operand),
        .skip       (skip),
        .mem        (m)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0o expected %0o (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [11:0] mem     [4096];
    logic [11:0] ref_mem [4096];
    logic        poke_en   = 1'b0;
    logic [11:0] poke_addr = '0;
    logic [11:0] poke_data = '0;

    always @(posedge clk) begin
        if (poke_en)       mem[poke_addr] <= poke_data;
        if (m.exec_wr_req) mem[m.exec_wr_addr] <= m.exec_wr_data;
        if (m.exec_rd_req) m.exec_rd_data <= mem[m.exec_rd_addr];
    end

    task automatic poke(input logic [11:0] a, input logic [11:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d; ref_mem[a] = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [11:0] ea;
        logic [11:0] op;
        bit          chk_op;
        bit          skip;
        int          lat;
        int          start_cyc;
    } exp_t;

    typedef struct {
        bit          is_wr;
        logic [11:0] addr;
        logic [11:0] data;
    } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];

    // Reference model: walks the architectural rules on its own memory image
    task automatic model(input logic [11:0] ins, input logic [11:0] p, input logic [1:0] acc,
                         input logic [11:0] wd, input int sc, input bit want_done);
        int   base, ptr, op, res, lat, eff;
        bit   skp;
        exp_t e;
        skp  = 1'b0;
        op   = 0;
        lat  = 0;
        base = int'(ins) % 128;
        if ((int'(ins) / 128) % 2 == 1) base += (int'(p) / 128) * 128;
        eff = base;
        if ((int'(ins) / 256) % 2 == 1) begin
            bus_q.push_back('{1'b0, 12'(base), 12'd0});
            ptr = int'(ref_mem[base]);
            lat += 2;
            if (base >= 8 && base <= 15) begin
                ptr = (ptr + 1) % 4096;
                ref_mem[base] = 12'(ptr);
                bus_q.push_back('{1'b1, 12'(base), 12'(ptr)});
                lat += 1;
            end
            eff = ptr;
        end
        case (acc)
            2'd0: begin
                bus_q.push_back('{1'b0, 12'(eff), 12'd0});
                op = int'(ref_mem[eff]);
                lat += 3;
            end
            2'd1: begin
                bus_q.push_back('{1'b1, 12'(eff), wd});
                ref_mem[eff] = wd;
                lat += 2;
            end
            2'd2: begin
                bus_q.push_back('{1'b0, 12'(eff), 12'd0});
                op  = int'(ref_mem[eff]);
                res = (op + 1) % 4096;
                bus_q.push_back('{1'b1, 12'(eff), 12'(res)});
                ref_mem[eff] = 12'(res);
                skp = (res == 0);
                lat += 4;
            end
            default: lat += 1;
        endcase
        e.ea = 12'(eff); e.op = 12'(op); e.chk_op = (acc == 2'd0 || acc == 2'd2);
        e.skip = skp; e.lat = lat; e.start_cyc = sc;
        if (want_done) exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    bit   prev_rd = 1'b0;
    bus_t mon_b;
    exp_t mon_e;

    always @(negedge clk) begin
        if (m.exec_rd_req) begin
            chk("rd_req_back_to_back", {31'd0, prev_rd}, 32'd0);
            if (bus_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_rd: addr %0o, none expected", m.exec_rd_addr);
            end else begin
                mon_b = bus_q.pop_front();
                chk("bus_kind_at_rd", {31'd0, mon_b.is_wr}, 32'd0);
                chk("rd_addr", {20'd0, m.exec_rd_addr}, {20'd0, mon_b.addr});
            end
        end else begin
            chk("rd_addr_idle", {20'd0, m.exec_rd_addr}, 32'd0);
        end
        if (m.exec_wr_req) begin
            if (bus_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_wr: addr %0o data %0o, none expected",
                         m.exec_wr_addr, m.exec_wr_data);
            end else begin
                mon_b = bus_q.pop_front();
                chk("bus_kind_at_wr", {31'd0, mon_b.is_wr}, 32'd1);
                chk("wr_addr", {20'd0, m.exec_wr_addr}, {20'd0, mon_b.addr});
                chk("wr_data", {20'd0, m.exec_wr_data}, {20'd0, mon_b.data});
            end
        end else begin
            chk("wr_bus_idle", {8'd0, m.exec_wr_addr, m.exec_wr_data}, 32'd0);
        end
        prev_rd = m.exec_rd_req;

        if (done) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_done: ea %0o, none expected", ea);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ea", {20'd0, ea}, {20'd0, mon_e.ea});
                if (mon_e.chk_op) chk("rd_operand", {20'd0, rd_operand}, {20'd0, mon_e.op});
                chk("skip", {31'd0, skip}, {31'd0, mon_e.skip});
                chk("latency", 32'(cyc - mon_e.start_cyc + 1), 32'(mon_e.lat));
                chk("busy_in_done", {31'd0, busy}, 32'd1);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_op(input logic [11:0] ins, input logic [11:0] p, input logic [1:0] acc,
                          input logic [11:0] wd, input bit poke_busy);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        instr = ins; pc = p; access = acc; wr_data = wd; start = 1'b1;
        model(ins, p, acc, wd, cyc + 1, 1'b1);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            // Any start here lands while busy or in DONE and must be ignored
            start = poke_busy && (n == 0);
            if (n == 0) begin
                instr = 12'($urandom); pc = 12'($urandom);
                access = 2'($urandom); wr_data = 12'($urandom);
            end
            if (done) begin
                seen = 1'b1;
                if (poke_busy) start = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL done_timeout: instr %0o pc %0o access %0d", ins, p, acc);
        end
        if (start) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_ea"}, {20'd0, ea}, 32'd0);
        chk({tag, "_rd_operand"}, {20'd0, rd_operand}, 32'd0);
        chk({tag, "_skip"}, {31'd0, skip}, 32'd0);
        chk({tag, "_reqs"}, {30'd0, m.exec_rd_req, m.exec_wr_req}, 32'd0);
        chk({tag, "_rd_addr"}, {20'd0, m.exec_rd_addr}, 32'd0);
        chk({tag, "_wr_bus"}, {8'd0, m.exec_wr_addr, m.exec_wr_data}, 32'd0);
    endtask

    initial begin
        logic [11:0] d, ins;
        int          bad;

        // Fill memory while held in reset
        poke_en = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            d = 12'($urandom);
            poke_addr = 12'(i); poke_data = d; ref_mem[i] = d;
        end
        @(negedge clk);
        poke_en = 1'b0;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Directed cases
        poke(12'o0045, 12'o1234);
        run_op(12'o1045, 12'o0200, 2'd0, 12'o0000, 1'b0);
        run_op(12'o3277, 12'o4321, 2'd1, 12'o7070, 1'b0);
        poke(12'o0020, 12'o5555);
        poke(12'o5555, 12'o0007);
        run_op(12'o1420, 12'o0200, 2'd0, 12'o0000, 1'b0);
        poke(12'o0010, 12'o7777);
        run_op(12'o1410, 12'o0200, 2'd0, 12'o0000, 1'b0);
        poke(12'o0050, 12'o7777);
        run_op(12'o2050, 12'o0200, 2'd2, 12'o0000, 1'b0);
        poke(12'o0050, 12'o0005);
        run_op(12'o2050, 12'o0200, 2'd2, 12'o0000, 1'b0);
        // start while busy and in DONE
        run_op(12'o2412, 12'o3300, 2'd2, 12'o0000, 1'b1);
        run_op(12'o3777, 12'o6543, 2'd1, 12'o1357, 1'b1);
        run_op(12'o5600, 12'o2000, 2'd3, 12'o0000, 1'b1);

        // Reset during OP_WAIT of a direct READ
        @(negedge clk);
        instr = 12'o1045; pc = 12'o0200; access = 2'd0; start = 1'b1;
        model(12'o1045, 12'o0200, 2'd0, 12'o0000, cyc + 1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("busy_before_reset", {31'd0, busy}, 32'd1);
        chk("ea_before_reset", {20'd0, ea}, 32'o0045);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midop_reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(12'o5600, 12'o1000, 2'd3, 12'o0000, 1'b0);

        // Randomized traffic, biased towards auto-index pointers
        for (int k = 0; k < 250; k++) begin
            ins = 12'($urandom);
            if ($urandom_range(0, 3) == 0)
                ins = {ins[11:9], 2'b10, 7'($urandom_range(8, 15))};
            run_op(ins, 12'($urandom), 2'($urandom), 12'($urandom),
                   ($urandom_range(0, 3) == 0));
        end

        repeat (5) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        bad = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_image_mismatches", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
